sysid_check_sequencer: RTL
==========================

SYSID_CHECK_SEQUENCER -- requirements
Module: sysid_check_sequencer

Interface
REQ-001 Parameter EXPECTED_ID, default 32'h0400_0000, system ID word expected at sysid address 0.
REQ-002 Parameter EXPECTED_TS, default 32'h5450_A0CA, build timestamp expected at sysid address 1.
REQ-003 Parameter TIMEOUT_CYCLES, default 255, maximum cycles per read transaction before abort.
REQ-004 Parameter MAX_RETRIES, default 3, re-read attempts after a failed read or mismatch.
REQ-005 clock  in  1  single clock; all logic rising-edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 start  in  1  one-cycle pulse; begins a check sequence.
REQ-008 avm_address  out  1  0 = ID word, 1 = timestamp word.
REQ-009 avm_read  out  1  Avalon-MM read strobe.
REQ-010 avm_waitrequest  in  1  slave stall; request held while high.
REQ-011 avm_readdatavalid  in  1  read data qualifier.
REQ-012 avm_readdata  in  32  read data.
REQ-013 busy  out  1  sequence in progress.
REQ-014 done  out  1  one-cycle pulse when the sequence ends (pass or fail).
REQ-015 sys_enable  out  1  high only after a passing check; gates motor-control enable.
REQ-016 error  out  1  sticky fail flag.
REQ-017 id_value / ts_value  out  32 each  last captured words.
REQ-018 retry_count  out  2  retries consumed in the current/last sequence.

Function
REQ-019 States SHALL be IDLE, RD_ID, WAIT_ID, RD_TS, WAIT_TS, CHECK, PASS, FAIL.
REQ-020 IDLE -> RD_ID on start; start SHALL be ignored in every other state.
REQ-021 RD_ID/RD_TS SHALL drive avm_read=1 with address 0/1 respectively and hold it until a cycle with avm_waitrequest=0, then move to WAIT_ID/WAIT_TS.
REQ-022 If waitrequest=0 and readdatavalid=1 in the same cycle, data SHALL be captured that cycle and the WAIT state skipped.
REQ-023 WAIT_* SHALL capture avm_readdata into id_value/ts_value on readdatavalid=1; WAIT_ID -> RD_TS, WAIT_TS -> CHECK.
REQ-024 An 8-bit timeout counter SHALL clear on entry to each RD_* state and increment each cycle in RD_*/WAIT_*; reaching TIMEOUT_CYCLES SHALL be treated as a failed attempt.
REQ-025 CHECK (one cycle) SHALL compare both words to EXPECTED_ID/EXPECTED_TS; match -> PASS, mismatch -> failed attempt.
REQ-026 A failed attempt with retry_count < MAX_RETRIES SHALL increment retry_count and return to RD_ID; otherwise -> FAIL.
REQ-027 PASS SHALL set sys_enable=1 and clear error; FAIL SHALL set error=1 and clear sys_enable; both pulse done and return to IDLE the next cycle.
REQ-028 sys_enable SHALL drop to 0 on entry to RD_ID from IDLE (re-check revokes enable).
REQ-029 busy SHALL be 1 in all states except IDLE.
REQ-030 retry_count SHALL clear on start accepted in IDLE; saturates at MAX_RETRIES.
REQ-031 readdatavalid outside WAIT_* (and outside REQ-022's case) SHALL be ignored.

Reset
REQ-032 reset SHALL override all inputs: state IDLE, avm_read=0, avm_address=0, busy=0, done=0, sys_enable=0, error=0, id_value=0, ts_value=0, retry_count=0, timeout counter=0.
REQ-033 reset asserted mid-transaction SHALL abandon the read; late readdatavalid afterwards is ignored.

Structure
REQ-034 State enumeration, sysid address constants (ID=0, TS=1) and default EXPECTED_* values SHALL live in a shared package sysid_ctrl_pkg.
REQ-035 One sub-module, sysid_read_timer (clearable saturating counter with expiry flag), SHALL be instantiated; all else in a single FSM.

Verification
REQ-036 Slave returns 32'h0400_0000 then 32'h5450_A0CA, zero waitrequest, 1-cycle latency; pulse start -> done after 6 cycles, sys_enable=1, error=0, retry_count=0.
REQ-037 waitrequest held 3 cycles on each read -> avm_read/avm_address stable during stall; same pass result.
REQ-038 Timestamp reads 32'h0000_0000 always -> 4 ID/TS read pairs, then error=1, sys_enable=0, retry_count=3, one done pulse.
REQ-039 readdatavalid never asserted -> abort after 255 cycles per attempt, FAIL after 4 attempts; first attempt mismatch then correct -> PASS with retry_count=1.
REQ-040 reset asserted during WAIT_TS, stale readdatavalid one cycle after release -> outputs at reset values, no capture, state IDLE.

Source files
------------

// File: rtl/sysid_ctrl_pkg.sv
// rtl/sysid_ctrl_pkg.sv - shared states, sysid addresses and default expected words
package sysid_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ID,
    ST_WAIT_ID,
    ST_RD_TS,
    ST_WAIT_TS,
    ST_CHECK,
    ST_PASS,
    ST_FAIL
  } state_e;

  localparam logic        SYSID_ADDR_ID       = 1'b0;
  localparam logic        SYSID_ADDR_TS       = 1'b1;
  localparam logic [31:0] DEFAULT_EXPECTED_ID = 32'h0400_0000;
  localparam logic [31:0] DEFAULT_EXPECTED_TS = 32'h5450_A0CA;
  localparam int unsigned TIMER_W             = 8;

  // States in which a bus read is outstanding and the timeout runs
  function automatic logic in_read_state(state_e s);
    return (s == ST_RD_ID) || (s == ST_WAIT_ID) || (s == ST_RD_TS) || (s == ST_WAIT_TS);
  endfunction

endpackage

// File: rtl/sysid_check_sequencer_if.sv
// rtl/sysid_check_sequencer_if.sv - Avalon-MM read port between sequencer and sysid slave
interface sysid_check_sequencer_if;

  logic        avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic        avm_readdatavalid;
  logic [31:0] avm_readdata;

  modport master (
    output avm_address,
    output avm_read,
    input  avm_waitrequest,
    input  avm_readdatavalid,
    input  avm_readdata
  );

  modport slave (
    input  avm_address,
    input  avm_read,
    output avm_waitrequest,
    output avm_readdatavalid,
    output avm_readdata
  );

endinterface

// File: rtl/sysid_read_timer.sv
// rtl/sysid_read_timer.sv - clearable saturating per-transaction cycle counter
// expired_o is raised during the LIMIT-th enabled cycle after a clear.
module sysid_read_timer
  import sysid_ctrl_pkg::*;
#(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam logic [TIMER_W-1:0] LAST = TIMER_W'(LIMIT - 1);
  localparam logic [TIMER_W-1:0] SAT  = '1;

  logic [TIMER_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && (count_q != SAT)) begin
      count_d = count_q + TIMER_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = enable_i && (count_q >= LAST);

endmodule

// File: rtl/sysid_check_sequencer.sv
// rtl/sysid_check_sequencer.sv - reads sysid ID/timestamp, compares, retries, gates sys_enable
module sysid_check_sequencer
  import sysid_ctrl_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = DEFAULT_EXPECTED_ID,
  parameter logic [31:0] EXPECTED_TS    = DEFAULT_EXPECTED_TS,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned MAX_RETRIES    = 3
) (
  input  logic                     clock_i,
  input  logic                     reset_i,
  input  logic                     start_i,
  sysid_check_sequencer_if.master  avm,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     sys_enable_o,
  output logic                     error_o,
  output logic [31:0]              id_value_o,
  output logic [31:0]              ts_value_o,
  output logic [1:0]               retry_count_o
);

  localparam logic [1:0] RETRY_MAX = (MAX_RETRIES > 3) ? 2'd3 : 2'(MAX_RETRIES);

  state_e      state_q, state_d;
  logic [1:0]  retry_q, retry_d;
  logic [31:0] id_q, id_d, ts_q, ts_d;
  logic        sys_enable_q, sys_enable_d;
  logic        error_q, error_d;
  logic        read_c, addr_c, timer_clr_c, fail_attempt_c, expired_c;

  sysid_read_timer #(.LIMIT(TIMEOUT_CYCLES)) u_timer (
    .clk_i     (clock_i),
    .rst_i     (reset_i),
    .clear_i   (timer_clr_c),
    .enable_i  (in_read_state(state_q)),
    .expired_o (expired_c)
  );

  always_comb begin
    state_d        = state_q;
    retry_d        = retry_q;
    id_d           = id_q;
    ts_d           = ts_q;
    sys_enable_d   = sys_enable_q;
    error_d        = error_q;
    read_c         = 1'b0;
    addr_c         = SYSID_ADDR_ID;
    timer_clr_c    = 1'b0;
    fail_attempt_c = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d      = ST_RD_ID;
          retry_d      = 2'd0;
          sys_enable_d = 1'b0;
          timer_clr_c  = 1'b1;
        end
      end
      ST_RD_ID: begin
        read_c = 1'b1;
        addr_c = SYSID_ADDR_ID;
        if (!avm.avm_waitrequest && avm.avm_readdatavalid) begin
          id_d        = avm.avm_readdata;
          state_d     = ST_RD_TS;
          timer_clr_c = 1'b1;
        end else if (expired_c) begin
          fail_attempt_c = 1'b1;
        end else if (!avm.avm_waitrequest) begin
          state_d = ST_WAIT_ID;
        end
      end
      ST_WAIT_ID: begin
        if (avm.avm_readdatavalid) begin
          id_d        = avm.avm_readdata;
          state_d     = ST_RD_TS;
          timer_clr_c = 1'b1;
        end else if (expired_c) begin
          fail_attempt_c = 1'b1;
        end
      end
      ST_RD_TS: begin
        read_c = 1'b1;
        addr_c = SYSID_ADDR_TS;
        if (!avm.avm_waitrequest && avm.avm_readdatavalid) begin
          ts_d    = avm.avm_readdata;
          state_d = ST_CHECK;
        end else if (expired_c) begin
          fail_attempt_c = 1'b1;
        end else if (!avm.avm_waitrequest) begin
          state_d = ST_WAIT_TS;
        end
      end
      ST_WAIT_TS: begin
        if (avm.avm_readdatavalid) begin
          ts_d    = avm.avm_readdata;
          state_d = ST_CHECK;
        end else if (expired_c) begin
          fail_attempt_c = 1'b1;
        end
      end
      ST_CHECK: begin
        if ((id_q == EXPECTED_ID) && (ts_q == EXPECTED_TS)) begin
          state_d      = ST_PASS;
          sys_enable_d = 1'b1;
          error_d      = 1'b0;
        end else begin
          fail_attempt_c = 1'b1;
        end
      end
      ST_PASS: state_d = ST_IDLE;
      ST_FAIL: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Timeouts and mismatches share one retry path
    if (fail_attempt_c) begin
      if (retry_q < RETRY_MAX) begin
        retry_d     = retry_q + 2'd1;
        state_d     = ST_RD_ID;
        timer_clr_c = 1'b1;
      end else begin
        state_d      = ST_FAIL;
        error_d      = 1'b1;
        sys_enable_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q      <= ST_IDLE;
      retry_q      <= 2'd0;
      id_q         <= '0;
      ts_q         <= '0;
      sys_enable_q <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      retry_q      <= retry_d;
      id_q         <= id_d;
      ts_q         <= ts_d;
      sys_enable_q <= sys_enable_d;
      error_q      <= error_d;
    end
  end

  assign avm.avm_read    = read_c;
  assign avm.avm_address = addr_c;
  assign busy_o          = (state_q != ST_IDLE);
  assign done_o          = (state_q == ST_PASS) || (state_q == ST_FAIL);
  assign sys_enable_o    = sys_enable_q;
  assign error_o         = error_q;
  assign id_value_o      = id_q;
  assign ts_value_o      = ts_q;
  assign retry_count_o   = retry_q;

endmodule
